fpu_issue_ctrl: RTL
===================

# fpu_issue_ctrl

Single-outstanding issue controller that drives the FPU top-level's request side (opcode, rounding mode, operands) and collects its result side (result, exception flags, compare flags). Accepts one operation per valid/ready handshake, holds the FPU inputs stable for a per-class latency, captures the result, and returns it with a tag over a valid/ready response channel. Sits between the integer pipeline/CSR logic and the FPU.

## Interface
- LAT_ADD, 2: cycles from FPU input-stable to valid output for FADD/FSUB.
- LAT_MUL, 3: same, for FMUL.
- LAT_DIV, 12: same, for FDIV.
- LAT_SQRT, 12: same, for FSQRT.
- LAT_CVT, 2: same, for all FCVT opcodes.
- CNT_W, 5: latency counter width; every LAT_* must be ≤ 2^CNT_W−1.
- TAG_W, 4: request/response tag width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_opcode  in  7  FPU opcode.
- req_rm  in  3  rounding mode.
- req_a, req_b  in  64  operands.
- req_tag  in  TAG_W  opaque tag.
- fpu_opcode, fpu_rounding_mode, fpu_operand_a, fpu_operand_b  out  7/3/64/64  to FPU.
- fpu_result  in  64.
- fpu_flags  in  4  {invalid, overflow, underflow, inexact}.
- fpu_cmp  in  4  {lt, eq, gt, unordered}.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_result  out  64; rsp_flags  out  4; rsp_cmp  out  4; rsp_tag  out  TAG_W.
- busy  out  1  state ≠ IDLE.
- fflags  out  4  sticky flags (FPU_FFLAGS_EN only).
- fflags_clr  in  1  clear sticky flags (FPU_FFLAGS_EN only).

## Operation
- States: IDLE, EXEC, RESP. req_ready = (state==IDLE). rsp_valid = (state==RESP).
- IDLE: on req_valid&req_ready, register opcode/rm/a/b/tag; load cnt with class latency; → EXEC.
- Opcode classes and latencies:
  - ADD: 0x00, 0x01, 0x04, 0x05 → LAT_ADD.
  - MUL: 0x08, 0x09 → LAT_MUL.
  - DIV: 0x0C, 0x0D → LAT_DIV.
  - SQRT: 0x2C, 0x2D → LAT_SQRT.
  - CMP: 0x50, 0x51 → 0.
  - CVT: 0x10–0x15 → LAT_CVT.
  - Any other opcode → 0; still issued, FPU returns QNaN 0x7FF8000000000000 with invalid.
- EXEC: cnt≠0 → decrement. cnt==0 → capture fpu_result, fpu_flags, fpu_cmp into rsp_*; → RESP.
- RESP: rsp_* held stable until rsp_valid&rsp_ready; then → IDLE. No new accept in the handshake cycle.
- fpu_* outputs always equal the registered request fields, unchanged from accept until the next accept.
- rsp_cmp is captured verbatim for every class; it is meaningful only for CMP.

## Timing
- Accept edge = E. rsp_valid rises after edge E+LAT+1. CMP/unknown opcodes: 1 cycle.
- Throughput: one operation per LAT+3 cycles when rsp_ready is held high.
- Reset values: state IDLE, all registered fields 0, rsp_valid 0, busy 0, req_ready 1, fflags 0.
- Reset mid-EXEC or mid-RESP: the operation is dropped and no response is produced.
- req_* inputs are ignored while req_ready=0.

## Configuration
- FPU_FFLAGS_EN defined:
  - fflags and fflags_clr exist.
  - On the capture edge, fflags ← (fflags_clr ? 0 : fflags) | fpu_flags. Capture and clear in the same cycle leave only the new flags.
  - fflags_clr with no capture → 0.
- Undefined: both ports are absent; no sticky state exists.

## Structure
- fpu_pkg holds:
  - opcode localparams;
  - op_class_e {ADD, MUL, DIV, SQRT, CMP, CVT, ILLEGAL};
  - fpu_flags_t packed struct {invalid, overflow, underflow, inexact};
  - fpu_cmp_t packed struct {lt, eq, gt, unordered}.
- Sub-module fpu_op_classifier: combinational opcode → op_class_e and latency.

## Test plan
- FADD_D, a=0x3FF0000000000000, b=0x4000000000000000 → rsp_result 0x4008000000000000, rsp_flags 0, rsp_valid LAT_ADD+1 cycles after accept.
- FCMP_S, a=0x3F800000, b=0x40000000 → rsp_cmp lt=1 (0b1000), rsp_valid 1 cycle after accept.
- FMUL_S issued with rsp_ready=0 for 5 cycles, second req_valid held → rsp_* stable, req_ready 0, second request accepted only after the response handshake.
- Opcode 0x7F → rsp_result 0x7FF8000000000000, rsp_flags 0b1000, latency 1.
- FPU_FFLAGS_EN: FSQRT_D a=0xBFF0000000000000 → fflags 0b1000; exact FADD → still 0b1000; fflags_clr → 0; clear coincident with a capture carrying inexact → 0b0001.
- rst_n low during FDIV EXEC → all outputs at reset values; after release req_ready=1 and no stray rsp_valid.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode constants, opcode classes and FPU flag/compare
// layouts used by the FPU issue controller and its opcode classifier.
package fpu_pkg;

  // Default per-class latencies and widths
  localparam int LAT_ADD  = 2;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 12;
  localparam int LAT_SQRT = 12;
  localparam int LAT_CVT  = 2;
  localparam int CNT_W    = 5;
  localparam int TAG_W    = 4;

  // FPU opcodes
  localparam logic [6:0] OP_FADD_S  = 7'h00;
  localparam logic [6:0] OP_FADD_D  = 7'h01;
  localparam logic [6:0] OP_FSUB_S  = 7'h04;
  localparam logic [6:0] OP_FSUB_D  = 7'h05;
  localparam logic [6:0] OP_FMUL_S  = 7'h08;
  localparam logic [6:0] OP_FMUL_D  = 7'h09;
  localparam logic [6:0] OP_FDIV_S  = 7'h0C;
  localparam logic [6:0] OP_FDIV_D  = 7'h0D;
  localparam logic [6:0] OP_FCVT_LO = 7'h10;
  localparam logic [6:0] OP_FCVT_HI = 7'h15;
  localparam logic [6:0] OP_FSQRT_S = 7'h2C;
  localparam logic [6:0] OP_FSQRT_D = 7'h2D;
  localparam logic [6:0] OP_FCMP_S  = 7'h50;
  localparam logic [6:0] OP_FCMP_D  = 7'h51;

  typedef enum logic [2:0] {
    ADD     = 3'd0,
    MUL     = 3'd1,
    DIV     = 3'd2,
    SQRT    = 3'd3,
    CMP     = 3'd4,
    CVT     = 3'd5,
    ILLEGAL = 3'd6
  } op_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic unordered;
  } fpu_cmp_t;

endpackage

// File: rtl/fpu_op_classifier.sv
// fpu_op_classifier: purely combinational decode of an FPU opcode into its
// operation class and the number of cycles the FPU needs for that class.
module fpu_op_classifier
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = fpu_pkg::LAT_ADD,
  parameter int LAT_MUL  = fpu_pkg::LAT_MUL,
  parameter int LAT_DIV  = fpu_pkg::LAT_DIV,
  parameter int LAT_SQRT = fpu_pkg::LAT_SQRT,
  parameter int LAT_CVT  = fpu_pkg::LAT_CVT,
  parameter int CNT_W    = fpu_pkg::CNT_W
) (
  input  logic [6:0]       opcode,
  output op_class_e        op_class,
  output logic [CNT_W-1:0] latency
);

  // Opcode to class, then class to latency
  always_comb begin
    op_class = ILLEGAL;
    latency  = '0;
    case (opcode)
      OP_FADD_S, OP_FADD_D, OP_FSUB_S, OP_FSUB_D: op_class = ADD;
      OP_FMUL_S, OP_FMUL_D:                       op_class = MUL;
      OP_FDIV_S, OP_FDIV_D:                       op_class = DIV;
      OP_FSQRT_S, OP_FSQRT_D:                     op_class = SQRT;
      OP_FCMP_S, OP_FCMP_D:                       op_class = CMP;
      default: begin
        if ((opcode >= OP_FCVT_LO) && (opcode <= OP_FCVT_HI)) begin
          op_class = CVT;
        end else begin
          op_class = ILLEGAL;
        end
      end
    endcase
    case (op_class)
      ADD:     latency = CNT_W'(LAT_ADD);
      MUL:     latency = CNT_W'(LAT_MUL);
      DIV:     latency = CNT_W'(LAT_DIV);
      SQRT:    latency = CNT_W'(LAT_SQRT);
      CVT:     latency = CNT_W'(LAT_CVT);
      default: latency = '0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-outstanding issue controller in front of the FPU.
// Accepts one request, holds the FPU inputs for the opcode's class latency,
// captures the FPU result and returns it with its tag.
// Optional feature macro: FPU_FFLAGS_EN adds sticky exception flags
// (fflags output, fflags_clr input).
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = fpu_pkg::LAT_ADD,
  parameter int LAT_MUL  = fpu_pkg::LAT_MUL,
  parameter int LAT_DIV  = fpu_pkg::LAT_DIV,
  parameter int LAT_SQRT = fpu_pkg::LAT_SQRT,
  parameter int LAT_CVT  = fpu_pkg::LAT_CVT,
  parameter int CNT_W    = fpu_pkg::CNT_W,
  parameter int TAG_W    = fpu_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_opcode,
  input  logic [2:0]       req_rm,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [6:0]       fpu_opcode,
  output logic [2:0]       fpu_rounding_mode,
  output logic [63:0]      fpu_operand_a,
  output logic [63:0]      fpu_operand_b,
  input  logic [63:0]      fpu_result,
  input  logic [3:0]       fpu_flags,
  input  logic [3:0]       fpu_cmp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       rsp_cmp,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef FPU_FFLAGS_EN
  ,
  output logic [3:0]       fflags,
  input  logic             fflags_clr
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       op_q, op_d;
  logic [2:0]       rm_q, rm_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      res_q, res_d;
  fpu_flags_t       flags_q, flags_d;
  fpu_cmp_t         cmp_q, cmp_d;

  op_class_e        op_class_s;
  logic [CNT_W-1:0] lat_s;
  logic [CNT_W-1:0] load_cnt_s;
  logic             capture_s;

  fpu_op_classifier #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT),
    .LAT_CVT (LAT_CVT),
    .CNT_W   (CNT_W)
  ) u_classifier (
    .opcode  (req_opcode),
    .op_class(op_class_s),
    .latency (lat_s)
  );

  // Latency to load at accept; compare and unknown opcodes never wait
  always_comb begin
    if ((op_class_s == CMP) || (op_class_s == ILLEGAL)) begin
      load_cnt_s = '0;
    end else begin
      load_cnt_s = lat_s;
    end
  end

  assign capture_s = (state_q == ST_EXEC) && (cnt_q == '0);

  // Next-state logic: accept in IDLE, count down in EXEC, hold in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rm_d    = rm_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    res_d   = res_q;
    flags_d = flags_q;
    cmp_d   = cmp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_opcode;
          rm_d    = req_rm;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          cnt_d   = load_cnt_s;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (capture_s) begin
          res_d   = fpu_result;
          flags_d = fpu_flags_t'(fpu_flags);
          cmp_d   = fpu_cmp_t'(fpu_cmp);
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state and request/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 7'd0;
      rm_q    <= 3'd0;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      tag_q   <= '0;
      res_q   <= 64'd0;
      flags_q <= '0;
      cmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cmp_q   <= cmp_d;
    end
  end

`ifdef FPU_FFLAGS_EN
  logic [3:0] fflags_q, fflags_d;

  // Sticky flags: a clear drops history, a capture ORs in the new flags
  always_comb begin
    if (fflags_clr) begin
      fflags_d = 4'd0;
    end else begin
      fflags_d = fflags_q;
    end
    if (capture_s) begin
      fflags_d = fflags_d | fpu_flags;
    end else begin
      fflags_d = fflags_d;
    end
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= 4'd0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags = fflags_q;
`endif

  assign req_ready         = (state_q == ST_IDLE);
  assign rsp_valid         = (state_q == ST_RESP);
  assign busy              = (state_q != ST_IDLE);
  assign fpu_opcode        = op_q;
  assign fpu_rounding_mode = rm_q;
  assign fpu_operand_a     = a_q;
  assign fpu_operand_b     = b_q;
  assign rsp_result        = res_q;
  assign rsp_flags         = flags_q;
  assign rsp_cmp           = cmp_q;
  assign rsp_tag           = tag_q;

endmodule
